// File: rtl/dnn_result_reader.sv
// Host-side reader for the inference engine: soft-resets and starts the engine,
// waits for done, sweeps the class scores for a signed argmax and hands the result over.
module dnn_result_reader #(
    parameter int DATA_WIDTH     = 4,
    parameter int NUM_CLASSES    = 10,
    parameter int IDX_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    output logic                         busy,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [IDX_WIDTH-1:0]         res_digit,
    output logic signed [DATA_WIDTH-1:0] res_max,
    output logic                         res_tie,
    output logic                         res_err,
    output logic                         eng_reset,
    output logic                         eng_start,
    input  logic                         eng_done,
    output logic [IDX_WIDTH-1:0]         eng_out_idx,
    input  logic signed [DATA_WIDTH-1:0] eng_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_SWEEP = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    localparam logic [15:0]          TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_ZERO = {IDX_WIDTH{1'b0}};

    state_t                         r_state;
    state_t                         w_next;
    logic [15:0]                    r_cnt;
    logic [IDX_WIDTH-1:0]           r_idx;
    logic [IDX_WIDTH-1:0]           r_digit;
    logic signed [DATA_WIDTH-1:0]   r_max;
    logic                           r_tie;
    logic                           r_err;
    logic                           w_timeout;
    logic                           w_first;
    logic                           w_last;
    logic                           w_gt;
    logic                           w_eq;

    // Compare and terminal-count flags for the current cycle
    always_comb begin
        w_timeout = (r_cnt == TO_LAST);
        w_first   = (r_idx == IDX_ZERO);
        w_last    = (r_idx == IDX_LAST);
        w_gt      = (eng_out > r_max);
        w_eq      = (eng_out == r_max);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req) w_next = S_CLEAR; else w_next = S_IDLE;
            S_CLEAR: w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (eng_done) begin
                    w_next = S_SWEEP;
                end else if (w_timeout) begin
                    w_next = S_HOLD;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_SWEEP: if (w_last) w_next = S_HOLD; else w_next = S_SWEEP;
            S_HOLD:  if (res_ready) w_next = S_IDLE; else w_next = S_HOLD;
            default: w_next = S_IDLE;
        endcase
    end

    // Timeout counter, sweep index and argmax result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= 16'd0;
            r_idx   <= IDX_ZERO;
            r_digit <= IDX_ZERO;
            r_max   <= {DATA_WIDTH{1'b0}};
            r_tie   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_START: r_cnt <= 16'd0;
                S_WAIT: begin
                    if (eng_done) begin
                        r_idx <= IDX_ZERO;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                        if (w_timeout) begin
                            r_err   <= 1'b1;
                            r_digit <= IDX_ZERO;
                            r_max   <= {DATA_WIDTH{1'b0}};
                            r_tie   <= 1'b0;
                        end
                    end
                end
                S_SWEEP: begin
                    // Strict greater-than keeps the lowest index on equal scores
                    if (w_first) begin
                        r_max   <= eng_out;
                        r_digit <= IDX_ZERO;
                        r_tie   <= 1'b0;
                        r_err   <= 1'b0;
                    end else if (w_gt) begin
                        r_max   <= eng_out;
                        r_digit <= r_idx;
                        r_tie   <= 1'b0;
                    end else if (w_eq) begin
                        r_tie   <= 1'b1;
                    end else begin
                        r_tie   <= r_tie;
                    end
                    if (!w_last) begin
                        r_idx <= r_idx + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign res_valid   = (r_state == S_HOLD);
    assign eng_reset   = (r_state == S_CLEAR);
    assign eng_start   = (r_state == S_START);
    assign eng_out_idx = r_idx;
    assign res_digit   = r_digit;
    assign res_max     = r_max;
    assign res_tie     = r_tie;
    assign res_err     = r_err;

endmodule

// File: doc/dnn_result_reader.md
Name: dnn_result_reader

Overview:
- Host-side controller for the inference engine top, driving the engine's start/reset and out_idx select and consuming its done and out.
- On a host request it soft-resets the engine, starts inference and waits for done.
- It then sweeps out_idx 0..NUM_CLASSES-1 and computes the signed argmax.
- It presents the result (digit, max score, tie flag, timeout error) to the host through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 4, width of signed class scores on eng_out.
- NUM_CLASSES, 10, number of output classes swept.
- IDX_WIDTH, 4, width of eng_out_idx and res_digit.
- TIMEOUT_CYCLES, 65535, maximum WAIT cycles before an error is flagged; the counter is 16 bits.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-low reset.
- req, input, 1, host request pulse/level; sampled only in IDLE.
- busy, output, 1, high in every state except IDLE.
- res_valid, output, 1, result available; held until accepted.
- res_ready, input, 1, host accepts the result.
- res_digit, output, IDX_WIDTH, argmax class index.
- res_max, output, DATA_WIDTH signed, winning score.
- res_tie, output, 1, another class equalled the max.
- res_err, output, 1, engine timed out.
- eng_reset, output, 1, engine soft reset, one cycle.
- eng_start, output, 1, engine start, one cycle.
- eng_done, input, 1, engine done, treated as a level.
- eng_out_idx, output, IDX_WIDTH, class select into the engine's combinational output mux.
- eng_out, input, DATA_WIDTH signed, score for eng_out_idx, valid in the same cycle.

Behaviour:
- Reset (rst==0 at a clk edge, any state including mid-sweep): state=IDLE. All outputs 0: busy, res_valid, res_digit, res_max, res_tie, res_err, eng_reset, eng_start, eng_out_idx. All counters 0.
- All outputs are registered or Moore-decoded from the state register; there is no combinational path from any input to any output.
- FSM states and transitions:
  - IDLE: if req=1, go to CLEAR.
  - CLEAR: eng_reset=1 for exactly this cycle; go to START.
  - START: eng_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: if eng_done=1, go to SWEEP with idx=0. Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, go to HOLD with res_err=1, res_digit=0, res_max=0, res_tie=0.
  - SWEEP: eng_out_idx=idx; eng_out is sampled in the same cycle.
    - idx==0: max=eng_out, digit=0, tie=0.
    - Otherwise, if eng_out > max (signed compare): max=eng_out, digit=idx, tie=0.
    - Otherwise, if eng_out == max: tie=1.
    - The lowest index wins ties.
    - At idx==NUM_CLASSES-1, go to HOLD; otherwise idx increments.
  - HOLD: res_valid=1 and result fields are stable. When res_ready=1, res_valid drops next cycle and the state returns to IDLE.
- Latency: req seen at edge t gives CLEAR in cycle t+1 and START in t+2. If done is first seen in WAIT at cycle d, idx 0..9 occupy d+1..d+10 and res_valid=1 from d+11.
- eng_out_idx holds its last value outside SWEEP, so it never exceeds NUM_CLASSES-1.
- req in any non-IDLE state is ignored and is not queued.
- req and res_ready both high in HOLD: only res_ready acts. Return to IDLE; req is resampled there.
- res_ready outside HOLD is ignored.
- eng_done already high on entry to WAIT (stale): not possible, because CLEAR resets the engine. The reader nevertheless accepts done on the first WAIT cycle.
- busy = (state != IDLE).
- Result registers keep their values after HOLD until the next sweep or error overwrites them.

Test Plan:
- Nominal: req pulse; model done 50 cycles after eng_start; scores {-2,1,3,0,-8,7,2,7,-1,5} → eng_reset then eng_start one cycle each. res_digit=5, res_max=7, res_tie=1, res_err=0. res_valid exactly 11 cycles after the first done cycle.
- All-negative: scores all -8 except idx9=-7 → digit=9, max=-7, tie=0. Confirms signed compare and that 4'b1000 is not treated as large.
- Timeout: done never asserted, TIMEOUT_CYCLES=20 → res_valid with res_err=1, digit=0, max=0. No out_idx sweep occurs.
- Backpressure/ignore: hold res_ready=0 for 30 cycles and pulse req during WAIT and HOLD → result stable and no restart. res_ready=1 → IDLE next cycle, busy=0.
- Reset mid-sweep: assert rst=0 while idx=4 → next cycle all outputs are 0 and state is IDLE. A fresh req completes normally with correct argmax.
- Back-to-back: req held high continuously with res_ready=1 → consecutive inferences. Each produces exactly one res_valid pulse; eng_start pulses are separated by a full cycle sequence.
